// File: rtl/apb_regbank_pkg.sv
// Shared types for the APB register bank: register access kinds, bus FSM states
// and the wait-state counter width.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_RO  = 2'd1,
        ACC_WO  = 2'd2,
        ACC_W1C = 2'd3
    } acc_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_cell.sv
// One register of the bank: reset value, byte-strobe merge and access-kind behaviour.
// RO cells hold no useful state; they pass hw_in through to the read path.
module apb_reg_cell
    import apb_regbank_pkg::*;
#(
    parameter int unsigned      DATAW   = 32,
    parameter acc_e             ACC     = ACC_RW,
    parameter logic [DATAW-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [DATAW-1:0]   wdata,
    input  logic [DATAW/8-1:0] wstrb,
    input  logic [DATAW-1:0]   hw_in,
    input  logic [DATAW-1:0]   hw_set,
    output logic [DATAW-1:0]   rdata,
    output logic [DATAW-1:0]   reg_q
);

    localparam int unsigned STRBW = DATAW / 8;

    logic [DATAW-1:0] value_q, value_d;
    logic [DATAW-1:0] bit_mask;

    always_comb begin
        bit_mask = '0;
        for (int unsigned b = 0; b < STRBW; b++) begin
            bit_mask[8*b +: 8] = {8{wstrb[b]}};
        end
    end

    always_comb begin
        value_d = value_q;
        case (ACC)
            ACC_RW, ACC_WO: begin
                if (wr_en) begin
                    value_d = (value_q & ~bit_mask) | (wdata & bit_mask);
                end
            end
            ACC_W1C: begin
                if (wr_en) begin
                    value_d = value_q & ~(wdata & bit_mask);
                end
                // Hardware set is applied last so it wins over a same-cycle clear.
                value_d = value_d | hw_set;
            end
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RST_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign rdata = (ACC == ACC_RO) ? hw_in : value_q;
    assign reg_q = (ACC == ACC_RO) ? '0 : value_q;

endmodule

// File: rtl/apb_regbank.sv
// APB slave exposing NREGS word-aligned registers with registered pready/prdata.
// Define APB_REGBANK_PSTRB_EN to add the pstrb port and per-byte-lane writes.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int unsigned            ADDRW       = 32,
    parameter int unsigned            DATAW       = 32,
    parameter int unsigned            NREGS       = 16,
    parameter int unsigned            WAIT_CYCLES = 0,
    parameter logic [2*NREGS-1:0]     ACC_TYPE    = '0,
    parameter logic [NREGS*DATAW-1:0] RST_VAL     = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDRW-1:0]       paddr,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [DATAW-1:0]       pwdata,
`ifdef APB_REGBANK_PSTRB_EN
    input  logic [DATAW/8-1:0]     pstrb,
`endif
    output logic [DATAW-1:0]       prdata,
    output logic                   pready,
    output logic                   pslverr,
    input  logic [NREGS*DATAW-1:0] hw_in,
    input  logic [NREGS*DATAW-1:0] hw_set,
    output logic [NREGS*DATAW-1:0] reg_q
);

    localparam int unsigned STRBW = DATAW / 8;
    localparam int unsigned IDXW  = ADDRW - 2;

    state_e                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATAW-1:0]      wdata_q, wdata_d;
    logic [DATAW-1:0]      prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic                  capture, commit;
    logic [STRBW-1:0]      wstrb;

    logic [IDXW-1:0]       idx;
    logic [NREGS-1:0]      hit;
    logic [NREGS-1:0]      wr_en;
    acc_e                  sel_acc;
    logic [DATAW-1:0]      rd_mux;
    logic                  err;
    logic [DATAW-1:0]      cell_rdata [NREGS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            StIdle: begin
                if (psel && !penable) begin
                    state_d = StAccess;
                    cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
                    capture = 1'b1;
                end
            end
            StAccess: begin
                if (!psel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (penable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end else begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d  = capture ? paddr  : addr_q;
        write_d = capture ? pwrite : write_q;
        wdata_d = capture ? pwdata : wdata_q;
    end

    assign idx = addr_q[ADDRW-1:2];

    // One-hot register select; no hit means the index lies beyond the bank.
    always_comb begin
        hit     = '0;
        sel_acc = ACC_RW;
        rd_mux  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == IDXW'(i)) begin
                hit[i]  = 1'b1;
                sel_acc = acc_e'(ACC_TYPE[2*i +: 2]);
                rd_mux  = cell_rdata[i];
            end
        end
    end

    assign err = ~|hit || (addr_q[1:0] != 2'b00) ||
                 (write_q && (sel_acc == ACC_RO)) || (!write_q && (sel_acc == ACC_WO));

    assign wr_en = (commit && write_q && !err) ? hit : '0;

    always_comb begin
        pready_d  = commit;
        pslverr_d = commit && err;
        prdata_d  = (commit && !err && !write_q) ? rd_mux : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

`ifdef APB_REGBANK_PSTRB_EN
    logic [STRBW-1:0] strb_q, strb_d;

    assign strb_d = capture ? pstrb : strb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= '0;
        end else begin
            strb_q <= strb_d;
        end
    end

    assign wstrb = strb_q;
`else
    assign wstrb = '1;
`endif

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        apb_reg_cell #(
            .DATAW   (DATAW),
            .ACC     (acc_e'(ACC_TYPE[2*i +: 2])),
            .RST_VAL (RST_VAL[i*DATAW +: DATAW])
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (wr_en[i]),
            .wdata  (wdata_q),
            .wstrb  (wstrb),
            .hw_in  (hw_in[i*DATAW +: DATAW]),
            .hw_set (hw_set[i*DATAW +: DATAW]),
            .rdata  (cell_rdata[i]),
            .reg_q  (reg_q[i*DATAW +: DATAW])
        );
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_regbank.sv
// Bench for apb_regbank: two instances (0 and 3 wait states) checked against an
// array-based register model. Honours APB_REGBANK_PSTRB_EN like the design.
module tb_apb_regbank;

    localparam logic [31:0]  ACC_TB = 32'h2078_D8D0;
    localparam logic [511:0] RST_TB = {
        32'hFFFF_000F, 32'hEEEE_000E, 32'hDDDD_000D, 32'hCCCC_000C,
        32'h0000_0000, 32'hFFFF_FFFF, 32'h9999_0009, 32'h8888_0008,
        32'h0F0F_0F0F, 32'h0000_0000, 32'h5555_0005, 32'h1122_3344,
        32'h0000_00FF, 32'h0000_0000, 32'h0000_0042, 32'h0000_0000};
    localparam int KRW = 0, KRO = 1, KWO = 2, KW1C = 3;

    int kind [16] = '{0, 0, 1, 3, 0, 2, 1, 3, 0, 2, 3, 1, 0, 0, 2, 0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  paddr, pwdata;
    logic         psel0, psel3, penable, pwrite;
`ifdef APB_REGBANK_PSTRB_EN
    logic [3:0]   pstrb;
`endif
    logic [511:0] hw_in, hw_set0, hw_set3, regq0, regq3;
    logic [31:0]  prdata0, prdata3;
    logic         pready0, pready3, pslverr0, pslverr3;

    logic [31:0]  mreg [2][16];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    apb_regbank #(
        .WAIT_CYCLES (0), .ACC_TYPE (ACC_TB), .RST_VAL (RST_TB)
    ) u_dut0 (
        .clk (clk), .rst_n (rst_n), .paddr (paddr), .psel (psel0), .penable (penable),
        .pwrite (pwrite), .pwdata (pwdata),
`ifdef APB_REGBANK_PSTRB_EN
        .pstrb (pstrb),
`endif
        .prdata (prdata0), .pready (pready0), .pslverr (pslverr0),
        .hw_in (hw_in), .hw_set (hw_set0), .reg_q (regq0)
    );

    apb_regbank #(
        .WAIT_CYCLES (3), .ACC_TYPE (ACC_TB), .RST_VAL (RST_TB)
    ) u_dut3 (
        .clk (clk), .rst_n (rst_n), .paddr (paddr), .psel (psel3), .penable (penable),
        .pwrite (pwrite), .pwdata (pwdata),
`ifdef APB_REGBANK_PSTRB_EN
        .pstrb (pstrb),
`endif
        .prdata (prdata3), .pready (pready3), .pslverr (pslverr3),
        .hw_in (hw_in), .hw_set (hw_set3), .reg_q (regq3)
    );

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int j = 0; j < 16; j++) mreg[d][j] = RST_TB[j*32 +: 32];
    endfunction

    // Transaction-level model: decode, error rules, access kinds, then hardware sets.
    function automatic void model_xfer(input int d, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       input logic [511:0] set, output logic [31:0] rd,
                                       output logic err);
        int unsigned idx = addr >> 2;
        logic [31:0] mask = '0;
`ifdef APB_REGBANK_PSTRB_EN
        for (int b = 0; b < 4; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
`else
        mask = 32'hFFFF_FFFF;
`endif
        rd = '0;
        if (addr[1:0] != 2'b00 || idx >= 16) err = 1'b1;
        else if (wr && kind[idx] == KRO) err = 1'b1;
        else if (!wr && kind[idx] == KWO) err = 1'b1;
        else err = 1'b0;
        if (!err) begin
            if (wr) begin
                if (kind[idx] == KW1C) mreg[d][idx] = mreg[d][idx] & ~(wdata & mask);
                else mreg[d][idx] = (mreg[d][idx] & ~mask) | (wdata & mask);
            end else begin
                rd = (kind[idx] == KRO) ? hw_in[idx*32 +: 32] : mreg[d][idx];
            end
        end
        for (int j = 0; j < 16; j++)
            if (kind[j] == KW1C) mreg[d][j] = mreg[d][j] | set[j*32 +: 32];
    endfunction

    function automatic logic [511:0] exp_regq(input int d);
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[j*32 +: 32] = (kind[j] == KRO) ? 32'h0 : mreg[d][j];
        return r;
    endfunction

    // One APB transfer on instance d; lat counts edges after the setup edge (-1 = timeout),
    // held reports pready one edge after it was first seen.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [511:0] set, output logic [31:0] rdata,
                            output logic err, output int lat, output logic held);
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
`ifdef APB_REGBANK_PSTRB_EN
        pstrb = strb;
`endif
        if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        if (d == 0) hw_set0 = set; else hw_set3 = set;
        lat = -1; rdata = '0; err = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if ((d == 0) ? pready0 : pready3) begin
                lat   = i;
                rdata = (d == 0) ? prdata0 : prdata3;
                err   = (d == 0) ? pslverr0 : pslverr3;
                break;
            end
        end
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; hw_set0 = '0; hw_set3 = '0;
        @(posedge clk); #1;
        held = (d == 0) ? pready0 : pready3;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; hw_in = '0; hw_set0 = '0; hw_set3 = '0;
`ifdef APB_REGBANK_PSTRB_EN
        pstrb = 4'hF;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL rst_pready got %b want 0", pready0); end
        checks++; if (pslverr0 !== 1'b0) begin failures++; $display("FAIL rst_pslverr got %b want 0", pslverr0); end
        checks++; if (prdata0 !== 32'h0) begin failures++; $display("FAIL rst_prdata got %h want 0", prdata0); end
        checks++; if (regq0 !== exp_regq(0)) begin failures++; $display("FAIL rst_regq0 got %h want %h", regq0, exp_regq(0)); end
        checks++; if (regq3 !== exp_regq(1)) begin failures++; $display("FAIL rst_regq3 got %h want %h", regq3, exp_regq(1)); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_reset_read();
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        apb_xfer(0, 1'b0, 32'h04, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b0, 32'h04, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== 32'h0000_0042) begin failures++; $display("FAIL rstval_read got %h want 00000042", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstval_err got %b want 0", err); end
        checks++; if (lat != 1) begin failures++; $display("FAIL rstval_latency got %0d want 1", lat); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL pready_one_cycle got %b want 0", held); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        apb_xfer(1, 1'b1, 32'h00, 32'hDEAD_BEEF, 4'hF, '0, rd, err, lat, held);
        model_xfer(1, 1'b1, 32'h00, 32'hDEAD_BEEF, 4'hF, '0, erd, eerr);
        checks++; if (lat != 4) begin failures++; $display("FAIL wait_wr_latency got %0d want 4", lat); end
        checks++; if (regq3[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wait_regq got %h want deadbeef", regq3[31:0]); end
        checks++; if (held !== 1'b0) begin failures++; $display("FAIL wait_pready_one_cycle got %b want 0", held); end
        apb_xfer(1, 1'b0, 32'h00, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(1, 1'b0, 32'h00, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wait_readback got %h want deadbeef", rd); end
        checks++; if (lat != 4) begin failures++; $display("FAIL wait_rd_latency got %0d want 4", lat); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4] = '{32'h40, 32'h08, 32'h02, 32'h14};
        logic        wrs   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        for (int k = 0; k < 4; k++) begin
            apb_xfer(0, wrs[k], addrs[k], 32'hFFFF_FFFF, 4'hF, '0, rd, err, lat, held);
            model_xfer(0, wrs[k], addrs[k], 32'hFFFF_FFFF, 4'hF, '0, erd, eerr);
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag addr=%h got %b want 1", addrs[k], err); end
            checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_prdata addr=%h got %h want 0", addrs[k], rd); end
            checks++; if (regq0 !== exp_regq(0)) begin failures++; $display("FAIL err_no_change addr=%h got %h want %h", addrs[k], regq0, exp_regq(0)); end
        end
    endtask

    task automatic test_w1c();
        logic [511:0] set = '0;
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        set[3*32 +: 32] = 32'h01;
        apb_xfer(0, 1'b1, 32'h0C, 32'h0F, 4'hF, set, rd, err, lat, held);
        model_xfer(0, 1'b1, 32'h0C, 32'h0F, 4'hF, set, erd, eerr);
        checks++; if (regq0[3*32 +: 32] !== 32'h0000_00F1) begin failures++; $display("FAIL w1c_set_wins got %h want 000000f1", regq0[3*32 +: 32]); end
        apb_xfer(0, 1'b0, 32'h0C, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b0, 32'h0C, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== 32'h0000_00F1) begin failures++; $display("FAIL w1c_readback got %h want 000000f1", rd); end
    endtask

    task automatic test_pstrb();
        logic [31:0] rd, erd, want; logic err, eerr, held; int lat;
`ifdef APB_REGBANK_PSTRB_EN
        want = 32'h11BB_33DD;
`else
        want = 32'hAABB_CCDD;
`endif
        apb_xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, '0, rd, err, lat, held);
        model_xfer(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, '0, erd, eerr);
        checks++; if (regq0[4*32 +: 32] !== want) begin failures++; $display("FAIL strobe_merge got %h want %h", regq0[4*32 +: 32], want); end
        apb_xfer(0, 1'b0, 32'h10, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b0, 32'h10, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== want) begin failures++; $display("FAIL strobe_readback got %h want %h", rd, want); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4] = '{32'h20, 32'h30, 32'h34, 32'h3C};
        logic [31:0] wd [4];
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        for (int k = 0; k < 4; k++) begin
            wd[k] = $urandom;
            apb_xfer(0, 1'b1, addrs[k], wd[k], 4'hF, '0, rd, err, lat, held);
            model_xfer(0, 1'b1, addrs[k], wd[k], 4'hF, '0, erd, eerr);
            checks++; if (lat != 1 || held !== 1'b0) begin failures++; $display("FAIL b2b_wr_timing k=%0d got lat=%0d held=%b want lat=1 held=0", k, lat, held); end
        end
        for (int k = 0; k < 4; k++) begin
            apb_xfer(0, 1'b0, addrs[k], '0, 4'hF, '0, rd, err, lat, held);
            model_xfer(0, 1'b0, addrs[k], '0, 4'hF, '0, erd, eerr);
            checks++; if (rd !== wd[k]) begin failures++; $display("FAIL b2b_readback k=%0d got %h want %h", k, rd, wd[k]); end
        end
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        @(negedge clk);
        paddr = 32'h00; pwrite = 1'b1; pwdata = 32'hC0FF_EE00; penable = 1'b0; psel0 = 1'b1;
        @(posedge clk); #1;
        psel0 = 1'b0; penable = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (pready0) seen = 1'b1; end
        penable = 1'b0;
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_pready got %b want 0", seen); end
        checks++; if (regq0 !== exp_regq(0)) begin failures++; $display("FAIL abort_no_write got %h want %h", regq0, exp_regq(0)); end
        apb_xfer(0, 1'b0, 32'h00, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b0, 32'h00, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== erd || lat != 1) begin failures++; $display("FAIL abort_next_read got %h/%0d want %h/1", rd, lat, erd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic err, eerr, held; int lat;
        apb_xfer(0, 1'b1, 32'h00, 32'h5A5A_5A5A, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b1, 32'h00, 32'h5A5A_5A5A, 4'hF, '0, erd, eerr);
        @(negedge clk);
        paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h0000_1234; penable = 1'b0; psel0 = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (pready0 !== 1'b0) begin failures++; $display("FAIL midrst_pready got %b want 0", pready0); end
        checks++; if (regq0 !== exp_regq(0)) begin failures++; $display("FAIL midrst_regs got %h want %h", regq0, exp_regq(0)); end
        psel0 = 1'b0; penable = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        apb_xfer(0, 1'b0, 32'h00, '0, 4'hF, '0, rd, err, lat, held);
        model_xfer(0, 1'b0, 32'h00, '0, 4'hF, '0, erd, eerr);
        checks++; if (rd !== RST_TB[31:0] || err !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL midrst_next_read got %h/%b/%0d want %h/0/1", rd, err, lat, RST_TB[31:0]);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, rd, erd; logic [3:0] strb; logic [511:0] set;
        logic wr, err, eerr, held; int lat, d, r, w1c_regs [3];
        w1c_regs = '{3, 7, 10};
        for (int n = 0; n < 150; n++) begin
            d = $urandom_range(0, 1);
            wr = 1'($urandom);
            wd = $urandom;
            strb = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0) addr = 32'h40 + ($urandom_range(0, 255) << 2);
            else if (r == 1) addr = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
            else addr = $urandom_range(0, 15) << 2;
            for (int j = 0; j < 16; j++) hw_in[j*32 +: 32] = $urandom;
            set = '0;
            if (wr && $urandom_range(0, 1) == 1)
                set[w1c_regs[$urandom_range(0, 2)]*32 +: 32] = $urandom & $urandom;
            apb_xfer(d, wr, addr, wd, strb, set, rd, err, lat, held);
            model_xfer(d, wr, addr, wd, strb, set, erd, eerr);
            checks++; if (err !== eerr) begin failures++; $display("FAIL rnd_err n=%0d addr=%h got %b want %b", n, addr, err, eerr); end
            checks++; if (rd !== erd) begin failures++; $display("FAIL rnd_prdata n=%0d addr=%h got %h want %h", n, addr, rd, erd); end
            checks++; if (lat != ((d == 0) ? 1 : 4)) begin failures++; $display("FAIL rnd_latency n=%0d got %0d want %0d", n, lat, (d == 0) ? 1 : 4); end
            checks++; if (((d == 0) ? regq0 : regq3) !== exp_regq(d)) begin
                failures++; $display("FAIL rnd_regq n=%0d dut=%0d got %h want %h", n, d, (d == 0) ? regq0 : regq3, exp_regq(d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_read();
        test_wait_states();
        test_errors();
        test_w1c();
        test_pstrb();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_regbank.md
APB_REGBANK -- requirements
Module: apb_regbank

Interface
REQ-001 SHALL have parameter ADDRW, default 32: APB address width.
REQ-002 SHALL have parameter DATAW, default 32: data width; multiple of 8.
REQ-003 SHALL have parameter NREGS, default 16: register count, 1..256; register i at byte offset 4*i.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: extra access-phase wait states, 0..15.
REQ-005 SHALL have parameter ACC_TYPE, default all-RW: 2 bits per register; 0=RW, 1=RO, 2=WO, 3=W1C.
REQ-006 SHALL have parameter RST_VAL, default 0: NREGS*DATAW packed reset values.
REQ-007 SHALL have ports in this order and form:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- paddr  in  ADDRW  byte address
- psel  in  1  select
- penable  in  1  access phase
- pwrite  in  1  1=write
- pwdata  in  DATAW  write data
- pstrb  in  DATAW/8  byte strobes (APB_REGBANK_PSTRB_EN only)
- prdata  out  DATAW  read data, registered
- pready  out  1  transfer complete, registered
- pslverr  out  1  error, valid with pready
- hw_in  in  NREGS*DATAW  RO register values from hardware
- hw_set  in  NREGS*DATAW  W1C set pulses from hardware
- reg_q  out  NREGS*DATAW  current RW/WO/W1C contents to hardware

Function
REQ-008 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-009 IDLE: psel && !penable at clock edge -> capture paddr, pwrite, pwdata (and pstrb); load wait counter with WAIT_CYCLES; go ACCESS.
REQ-010 ACCESS: psel && penable with counter nonzero -> decrement; counter zero -> go RESP, asserting pready on that edge.
REQ-011 ACCESS with psel low -> abort to IDLE; no write, no pready.
REQ-012 RESP: pready=1 for exactly one cycle, then IDLE; back-to-back setup in the cycle after RESP is accepted.
REQ-013 Latency: setup sampled at edge N -> pready high during cycle N+2+WAIT_CYCLES.
REQ-014 Write commits on the edge entering RESP; read data registered on the same edge; prdata=0 outside RESP.
REQ-015 pslverr=1 in RESP for: index >= NREGS, paddr[1:0] != 0, write to RO, read of WO; no side effect; prdata=0.
REQ-016 RW: read returns stored value; write replaces it.
REQ-017 RO: read returns hw_in sampled on the RESP-entry edge.
REQ-018 WO: write replaces value; visible only on reg_q.
REQ-019 W1C: hw_set bit sets; written 1 clears; same-cycle set and clear of one bit -> set wins.
REQ-020 reg_q SHALL be 0 for RO registers.

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, counter 0, prdata 0, pready 0, pslverr 0, each register to its RST_VAL slice.
REQ-022 Reset mid-transfer SHALL abandon it with no write; first transfer after release starts from IDLE.

Configuration
REQ-023 APB_REGBANK_PSTRB_EN defined: pstrb port present; byte lanes with pstrb=0 keep their old value (W1C: no clear in those lanes).
REQ-024 APB_REGBANK_PSTRB_EN undefined: no pstrb port; all byte lanes written.

Structure
REQ-025 Package apb_regbank_pkg SHALL hold the access-type enum (ACC_RW/RO/WO/W1C), the FSM state enum and the width constant for the wait counter.
REQ-026 One sub-module apb_reg_cell SHALL implement a single register (access type, reset value, strobe merge, W1C logic), instantiated NREGS times with generate.

Verification (DATAW=32, NREGS=16, WAIT_CYCLES=0 unless stated)
REQ-027 Reset release, read 0x04 with RST_VAL[1]=0x0000_0042 -> prdata=0x0000_0042, pslverr=0, pready at setup+2.
REQ-028 WAIT_CYCLES=3: write 0xDEAD_BEEF to 0x00 -> pready at setup+5; reg_q[31:0]=0xDEAD_BEEF; readback matches.
REQ-029 Read 0x40 (index 16), write RO 0x08, unaligned 0x02 -> pslverr=1, prdata=0, no register change.
REQ-030 W1C at 0x0C holding 0xFF; write 0x0F with hw_set=0x01 same cycle -> value 0xF1.
REQ-031 PSTRB_EN: reg 0x10=0x1122_3344, write 0xAABB_CCDD with pstrb=0b0101 -> 0x11BB_33DD.
REQ-032 Assert rst_n low during ACCESS of write 0x1234 to 0x00 -> register returns to RST_VAL, no pready; next read completes normally.
